button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 246 ++++++++++++++++++++++++
 tb/tb_button_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel button debouncer with edge, long-press and auto-repeat events
//
// Purpose: synchronizes N_BTN raw button inputs, debounces them on a shared
// sample tick, and reports press/release pulses, a long-press event and
// (optionally) auto-repeat events per channel.
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   btn_in       in   N_BTN  raw asynchronous buttons, 1 = pressed
//   btn_level    out  N_BTN  debounced level
//   rise_pulse   out  N_BTN  press event, PULSE_LEN cycles
//   fall_pulse   out  N_BTN  release event, PULSE_LEN cycles
//   long_pulse   out  N_BTN  long-press event, 1 cycle
//   repeat_pulse out  N_BTN  auto-repeat event, 1 cycle
//   tick         out  1      shared sample strobe, 1 cycle every TICK_DIV cycles
//
// Configuration macro: BTN_AUTOREPEAT_EN compiles in the HELD-state repeat
// counter; when undefined repeat_pulse is tied to 0 and HELD lasts until release.

module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_CNT   = 8,
    parameter int PULSE_LEN    = 4,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] rise_pulse,
    output logic [N_BTN-1:0] fall_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int LW = $clog2(PULSE_LEN + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    if (TICK_DIV < 2 || STABLE_CNT < 1 || PULSE_LEN < 1 || PULSE_LEN >= TICK_DIV ||
        LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("button_conditioner: invalid parameter set");
    end

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [SW-1:0]    r_stab     [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [LW-1:0]    r_rise_cnt [N_BTN];
    logic [LW-1:0]    r_fall_cnt [N_BTN];
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    state_t           r_state     [N_BTN];
    state_t           w_state_nxt [N_BTN];
    logic [HW-1:0]    r_hold      [N_BTN];
    logic [HW-1:0]    w_hold_nxt  [N_BTN];
    logic [N_BTN-1:0] w_long_evt;
    logic [N_BTN-1:0] r_long;

    assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
    assign tick      = w_tick;
    assign btn_level = r_level;
    assign long_pulse = r_long;

    // Level toggles on the tick where the mismatch has persisted for
    // STABLE_CNT ticks; these flags mark that tick cycle, so the new level
    // and its pulse become visible together on the following cycle.
    always_comb begin
        w_rise = '0;
        w_fall = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_tick && (r_sync2[i] != r_level[i]) && (r_stab[i] == SW'(STABLE_CNT - 1))) begin
                w_rise[i] = ~r_level[i];
                w_fall[i] = r_level[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_presc <= '0;
            r_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_stab[i]     <= '0;
                r_rise_cnt[i] <= '0;
                r_fall_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            for (int i = 0; i < N_BTN; i++) begin
                if (w_tick) begin
                    if (r_sync2[i] == r_level[i]) begin
                        r_stab[i] <= '0;
                    end else if (w_rise[i] || w_fall[i]) begin
                        r_stab[i]  <= '0;
                        r_level[i] <= ~r_level[i];
                    end else begin
                        r_stab[i] <= r_stab[i] + SW'(1);
                    end
                end
                if (w_rise[i]) begin
                    r_rise_cnt[i] <= LW'(PULSE_LEN);
                end else if (r_rise_cnt[i] != '0) begin
                    r_rise_cnt[i] <= r_rise_cnt[i] - LW'(1);
                end
                if (w_fall[i]) begin
                    r_fall_cnt[i] <= LW'(PULSE_LEN);
                end else if (r_fall_cnt[i] != '0) begin
                    r_fall_cnt[i] <= r_fall_cnt[i] - LW'(1);
                end
            end
        end
    end

    always_comb begin
        rise_pulse = '0;
        fall_pulse = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise_pulse[i] = (r_rise_cnt[i] != '0);
            fall_pulse[i] = (r_fall_cnt[i] != '0);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0]    r_rep     [N_BTN];
    logic [RW-1:0]    w_rep_nxt [N_BTN];
    logic [N_BTN-1:0] w_rep_evt;
    logic [N_BTN-1:0] r_rep_pulse;
    assign repeat_pulse = r_rep_pulse;
`else
    assign repeat_pulse = '0;
`endif

    // Next-state logic. A fall always takes priority, so a threshold reached
    // on the same tick as a release never produces a long/repeat event.
    always_comb begin
        w_long_evt = '0;
`ifdef BTN_AUTOREPEAT_EN
        w_rep_evt = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hold_nxt[i]  = r_hold[i];
`ifdef BTN_AUTOREPEAT_EN
            w_rep_nxt[i]   = r_rep[i];
`endif
            case (r_state[i])
                RELEASED: begin
                    if (w_rise[i]) begin
                        w_state_nxt[i] = PRESSED;
                        w_hold_nxt[i]  = '0;
                    end
                end
                PRESSED: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = RELEASED;
                        w_hold_nxt[i]  = '0;
                    end else if (w_tick) begin
                        if (r_hold[i] == HW'(LONG_TICKS - 1)) begin
                            w_long_evt[i]  = 1'b1;
                            w_state_nxt[i] = HELD;
                            w_hold_nxt[i]  = HW'(LONG_TICKS);
`ifdef BTN_AUTOREPEAT_EN
                            w_rep_nxt[i]   = '0;
`endif
                        end else begin
                            w_hold_nxt[i] = r_hold[i] + HW'(1);
                        end
                    end
                end
                HELD: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = RELEASED;
                        w_hold_nxt[i]  = '0;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep_nxt[i]   = '0;
                    end else if (w_tick) begin
                        if (r_rep[i] == RW'(REPEAT_TICKS - 1)) begin
                            w_rep_evt[i] = 1'b1;
                            w_rep_nxt[i] = '0;
                        end else begin
                            w_rep_nxt[i] = r_rep[i] + RW'(1);
                        end
`endif
                    end
                end
                default: begin
                    w_state_nxt[i] = RELEASED;
                    w_hold_nxt[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_long <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= RELEASED;
                r_hold[i]  <= '0;
            end
        end else begin
            r_long <= w_long_evt;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_pulse <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_rep[i] <= '0;
            end
        end else begin
            r_rep_pulse <= w_rep_evt;
            for (int i = 0; i < N_BTN; i++) begin
                r_rep[i] <= w_rep_nxt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner

module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] btn_level;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;
    logic [1:0] long_pulse;
    logic [1:0] repeat_pulse;
    logic       tick;

    button_conditioner #(
        .N_BTN(2), .TICK_DIV(10), .STABLE_CNT(4), .PULSE_LEN(4),
        .LONG_TICKS(20), .REPEAT_TICKS(5)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .tick(tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sole writer of all observation counters, sampled on negedge.
    int rise_hi [2] = '{0, 0};
    int fall_hi [2] = '{0, 0};
    int long_n  [2] = '{0, 0};
    int rep_n   [2] = '{0, 0};
    int lvl_rise_n [2] = '{0, 0};
    int lvl_rise_cyc [2] = '{0, 0};
    int lvl_fall_cyc [2] = '{0, 0};
    int long_cyc0 = 0;
    int rep_cyc0 = 0;
    int tick_n = 0;
    logic [1:0] lvl_prev = 2'b00;

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            rise_hi[ch] <= rise_hi[ch] + int'(rise_pulse[ch]);
            fall_hi[ch] <= fall_hi[ch] + int'(fall_pulse[ch]);
            long_n[ch]  <= long_n[ch] + int'(long_pulse[ch]);
            rep_n[ch]   <= rep_n[ch] + int'(repeat_pulse[ch]);
            if (btn_level[ch] && !lvl_prev[ch]) begin
                lvl_rise_n[ch]   <= lvl_rise_n[ch] + 1;
                lvl_rise_cyc[ch] <= cyc;
            end
            if (!btn_level[ch] && lvl_prev[ch]) lvl_fall_cyc[ch] <= cyc;
        end
        if (long_pulse[0]) long_cyc0 <= cyc;
        if (repeat_pulse[0]) rep_cyc0 <= cyc;
        tick_n   <= tick_n + int'(tick);
        lvl_prev <= btn_level;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    // Waits (bounded) for the next debounced rise of a channel.
    task automatic wait_lvl_rise(input int ch, input int budget, input string name);
        int base;
        int n;
        base = lvl_rise_n[ch];
        n = 0;
        while (lvl_rise_n[ch] == base && n < budget) begin
            step(1);
            n++;
        end
        if (lvl_rise_n[ch] == base) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_rise required=rise_within_%0d", name, budget);
        end
    endtask

    typedef struct {
        logic [1:0] press;
        int         hold;
        logic [1:0] exp_lvl;
        int         exp_rise0;
        int         exp_rise1;
        int         exp_fall0;
        int         exp_fall1;
        int         exp_long;
        bit         chk_sim;
    } vec_t;

    vec_t vt [5];

    initial begin : main
        int k, l, r, s0, s1, s2, s3, s4, s5;
        vt[0] = '{2'b01, 100, 2'b01, 4, 0, 4, 0, 0, 1'b0};
        vt[1] = '{2'b10,  25, 2'b00, 0, 0, 0, 0, 0, 1'b0};
        vt[2] = '{2'b11, 100, 2'b11, 4, 4, 4, 4, 0, 1'b1};
        vt[3] = '{2'b01,   5, 2'b00, 0, 0, 0, 0, 0, 1'b0};
        vt[4] = '{2'b10,  60, 2'b10, 0, 4, 0, 4, 0, 1'b0};

        step(3);
        @(negedge clk);
        chk("reset_outputs", int'({btn_level, rise_pulse, fall_pulse, long_pulse, repeat_pulse, tick}), 0);
        step(1);
        reset = 1'b0;
        s0 = tick_n;
        step(100);
        chk("tick_count_100", tick_n - s0, 10);

        for (int v = 0; v < 5; v++) begin
            s0 = rise_hi[0]; s1 = rise_hi[1]; s2 = fall_hi[0]; s3 = fall_hi[1];
            s4 = long_n[0] + long_n[1];
            btn_in = vt[v].press;
            step(vt[v].hold);
            chk($sformatf("v%0d_level", v), int'(btn_level), int'(vt[v].exp_lvl));
            btn_in = 2'b00;
            step(80);
            chk($sformatf("v%0d_rise0", v), rise_hi[0] - s0, vt[v].exp_rise0);
            chk($sformatf("v%0d_rise1", v), rise_hi[1] - s1, vt[v].exp_rise1);
            chk($sformatf("v%0d_fall0", v), fall_hi[0] - s2, vt[v].exp_fall0);
            chk($sformatf("v%0d_fall1", v), fall_hi[1] - s3, vt[v].exp_fall1);
            chk($sformatf("v%0d_long", v), long_n[0] + long_n[1] - s4, vt[v].exp_long);
            if (vt[v].chk_sim) begin
                chk("sim_rise_cycle", lvl_rise_cyc[1], lvl_rise_cyc[0]);
                chk("sim_fall_cycle", lvl_fall_cyc[1], lvl_fall_cyc[0]);
            end
        end

        // Long press held 300 cycles: latency, pulse width, long and repeat timing.
        s0 = rise_hi[0]; s1 = long_n[0]; s2 = rep_n[0];
        k = cyc;
        btn_in = 2'b01;
        wait_lvl_rise(0, 100, "long_rise_wait");
        l = lvl_rise_cyc[0];
        chk("rise_latency_33_to_42", int'((l - k) >= 33 && (l - k) <= 42), 1);
        wait_until(k + 300);
        btn_in = 2'b00;
        step(80);
        chk("long_rise_width", rise_hi[0] - s0, 4);
        chk("long_count", long_n[0] - s1, 1);
        chk("long_delay", long_cyc0 - l, 200);
`ifdef BTN_AUTOREPEAT_EN
        // Second repeat would coincide with the release tick and is suppressed.
        chk("repeat_count", rep_n[0] - s2, 1);
        chk("repeat_gap", rep_cyc0 - long_cyc0, 50);
`else
        chk("repeat_count", rep_n[0] - s2, 0);
`endif

        // Release lands on the tick where the hold count reaches LONG_TICKS.
        s0 = fall_hi[0]; s1 = long_n[0];
        btn_in = 2'b01;
        wait_lvl_rise(0, 100, "race_rise_wait");
        l = lvl_rise_cyc[0];
        wait_until(l + 162);
        btn_in = 2'b00;
        step(80);
        chk("race_fall_width", fall_hi[0] - s0, 4);
        chk("race_no_long", long_n[0] - s1, 0);
        chk("race_fall_cycle", lvl_fall_cyc[0] - l, 200);

        // Reset two cycles into the rise pulse, input stays pressed.
        btn_in = 2'b01;
        wait_lvl_rise(0, 100, "rst_rise_wait");
        l = lvl_rise_cyc[0];
        wait_until(l + 2);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_abort", int'({btn_level, rise_pulse, fall_pulse, long_pulse, repeat_pulse, tick}), 0);
        step(2);
        reset = 1'b0;
        r = cyc;
        s0 = rise_hi[0];
        wait_lvl_rise(0, 100, "post_reset_rise_wait");
        chk("post_reset_rise_delay", lvl_rise_cyc[0] - r, 40);
        step(10);
        chk("post_reset_rise_width", rise_hi[0] - s0, 4);
        btn_in = 2'b00;
        step(80);
        chk("final_level", int'(btn_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
